arb_req_master: RTL and testbench

Requester-side front end for the 4-way round-robin arbiter, driving the other end of its `req`/`gnt` interface. Each client posts transactions by pulsing `push_i`, and the block keeps a pending count per client. It raises `req_o` for every client with pending work and accepts one-hot grants back from the arbiter. For each accepted grant it runs a fixed-length transfer window on a shared transfer engine, then retires the transaction with a `done_o` pulse.

---
 rtl/arb_req_pkg.sv | 15 +
 rtl/arb_req_chan.sv | 41 ++++
 rtl/arb_req_master.sv | 148 ++++++++++++++
 tb/tb_arb_req_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_req_pkg.sv
// Package for the arb_req_master requester front end.
// Holds the transfer FSM state type and the default configuration values
// shared by arb_req_master and arb_req_chan.
package arb_req_pkg;

  localparam int unsigned DEF_N        = 4;  // clients, equals arbiter port count
  localparam int unsigned DEF_CNT_W    = 3;  // pending counter width
  localparam int unsigned DEF_XFER_LEN = 2;  // cycles per transfer window

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

endpackage

// File: rtl/arb_req_chan.sv
// arb_req_chan: per-client pending-transaction counter.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-low reset
//   push     in   enqueue strobe, dropped when the counter is at max
//   done     in   retire strobe for one transaction of this client
//   pend_nz  out  at least one transaction pending (request qualifier)
//   full     out  counter is at its maximum value
module arb_req_chan
  import arb_req_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic done,
  output logic pend_nz,
  output logic full
);

  logic [CNT_W-1:0] r_pend;

  // A push that coincides with a done is accepted even at max, since the
  // slot freed by the done absorbs it; the count simply holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else if (push && !done && (r_pend != '1)) begin
      r_pend <= r_pend + CNT_W'(1);
    end else if (done && !push) begin
      r_pend <= r_pend - CNT_W'(1);
    end
  end

  always_comb begin
    pend_nz = (r_pend != '0);
    full    = (r_pend == '1);
  end

endmodule

// File: rtl/arb_req_master.sv
// arb_req_master: requester-side front end for the N-way round-robin arbiter.
// Keeps a pending count per client, requests for every client with pending
// work, accepts one-hot grants and runs a fixed XFER_LEN-cycle transfer
// window per grant, retiring the transaction with a done pulse.
// Optional protocol checker: define ARB_REQ_GNT_CHECK_EN to compile it in;
// otherwise err_o is tied low.
// Ports:
//   clk           in   clock
//   reset         in   asynchronous active-low reset
//   push_i[N]     in   per-client enqueue strobe
//   full_o[N]     out  client pending count at maximum
//   req_o[N]      out  request vector to arbiter
//   gnt_i[N]      in   grant vector from arbiter (one-hot or zero)
//   xfer_valid_o  out  transfer window active
//   xfer_id_o     out  owner of the current window
//   done_o[N]     out  pulse on the last cycle of a client's window
//   err_o         out  sticky grant protocol error
module arb_req_master
  import arb_req_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned XFER_LEN = DEF_XFER_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         push_i,
  output logic [N-1:0]         full_o,
  output logic [N-1:0]         req_o,
  input  logic [N-1:0]         gnt_i,
  output logic                 xfer_valid_o,
  output logic [$clog2(N)-1:0] xfer_id_o,
  output logic [N-1:0]         done_o,
  output logic                 err_o
);

  localparam int unsigned ID_W   = $clog2(N);
  localparam int unsigned BEAT_W = $clog2(XFER_LEN + 1);

  state_t            r_state;
  logic [ID_W-1:0]   r_id;
  logic [BEAT_W-1:0] r_beat;

  logic [N-1:0]      w_pend_nz;
  logic [N-1:0]      w_req;
  logic [N-1:0]      w_acc;
  logic [N-1:0]      w_done;
  logic [ID_W-1:0]   w_sel;
  logic              w_found;
  logic              w_last;

  for (genvar g = 0; g < N; g++) begin : g_chan
    arb_req_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .push    (push_i[g]),
      .done    (w_done[g]),
      .pend_nz (w_pend_nz[g]),
      .full    (full_o[g])
    );
  end

  always_comb begin
    w_req  = (r_state == ST_IDLE) ? w_pend_nz : '0;
    w_acc  = gnt_i & w_req;
    w_last = (r_state == ST_XFER) && (r_beat == '0);
  end

  // Lowest accepted index wins if the arbiter misbehaves and grants several.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_acc[i] && !w_found) begin
        w_sel   = ID_W'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_done = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_done[i] = w_last && (r_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc != '0) begin
            r_id    <= w_sel;
            r_beat  <= BEAT_W'(XFER_LEN - 1);
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (r_beat == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_beat <= r_beat - BEAT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_o        = w_req;
    xfer_valid_o = (r_state == ST_XFER);
    xfer_id_o    = r_id;
    done_o       = w_done;
  end

`ifdef ARB_REQ_GNT_CHECK_EN
  logic r_err;
  logic w_multi;
  logic w_viol;

  always_comb begin
    w_multi = ((gnt_i & (gnt_i - N'(1))) != '0);
    w_viol  = w_multi
            || ((r_state == ST_IDLE) && ((gnt_i & ~w_req) != '0))
            || ((r_state == ST_XFER) && (gnt_i != '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_viol) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_master.sv
module tb_arb_req_master;

  logic       clk;
  logic       reset;
  logic [3:0] push_i;
  logic [3:0] full_o;
  logic [3:0] req_o;
  logic [3:0] gnt_i;
  logic       xfer_valid_o;
  logic [1:0] xfer_id_o;
  logic [3:0] done_o;
  logic       err_o;

`ifdef ARB_REQ_GNT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  arb_req_master #(
    .N        (4),
    .CNT_W    (3),
    .XFER_LEN (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_i),
    .full_o       (full_o),
    .req_o        (req_o),
    .gnt_i        (gnt_i),
    .xfer_valid_o (xfer_valid_o),
    .xfer_id_o    (xfer_id_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    int          order [4];
    logic [3:0]  rem;
    logic [3:0]  bit_k;

    order  = '{3, 0, 1, 2};
    reset  = 1'b0;
    push_i = '0;
    gnt_i  = '0;

    // Reset state
    tick();
    chk("rst_req",   32'(req_o), 32'h0);
    chk("rst_valid", 32'(xfer_valid_o), 32'h0);
    chk("rst_done",  32'(done_o), 32'h0);
    chk("rst_full",  32'(full_o), 32'h0);
    chk("rst_id",    32'(xfer_id_o), 32'h0);
    chk("rst_err",   32'(err_o), 32'h0);
    reset = 1'b1;
    tick(); tick(); tick();
    chk("idle_req",   32'(req_o), 32'h0);
    chk("idle_valid", 32'(xfer_valid_o), 32'h0);
    chk("idle_err",   32'(err_o), 32'h0);

    // Single push on client 2
    push_i = 4'b0100;
    tick();
    push_i = '0;
    chk("c2_req", 32'(req_o), 32'h4);
    gnt_i = 4'b0100;
    tick();
    gnt_i = '0;
    chk("c2_valid1", 32'(xfer_valid_o), 32'h1);
    chk("c2_id",     32'(xfer_id_o), 32'h2);
    chk("c2_done1",  32'(done_o), 32'h0);
    chk("c2_reqx",   32'(req_o), 32'h0);
    tick();
    chk("c2_valid2", 32'(xfer_valid_o), 32'h1);
    chk("c2_done2",  32'(done_o), 32'h4);
    tick();
    chk("c2_valid3", 32'(xfer_valid_o), 32'h0);
    chk("c2_done3",  32'(done_o), 32'h0);
    chk("c2_req3",   32'(req_o), 32'h0);

    // All four clients push together, served in rotating order
    push_i = 4'b1111;
    tick();
    push_i = '0;
    chk("all_req", 32'(req_o), 32'hF);
    rem = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      bit_k = 4'b0001 << order[k];
      gnt_i = bit_k;
      tick();
      gnt_i = '0;
      chk("all_valid", 32'(xfer_valid_o), 32'h1);
      chk("all_id",    32'(xfer_id_o), 32'(order[k]));
      chk("all_nodone", 32'(done_o), 32'h0);
      tick();
      chk("all_done", 32'(done_o), 32'(bit_k));
      rem = rem & ~bit_k;
      tick();
      chk("all_req_rem", 32'(req_o), 32'(rem));
      chk("all_idle",    32'(xfer_valid_o), 32'h0);
    end

    // Eight pushes on client 0 with no grants: saturates at 7
    push_i = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) chk("c0_full6", 32'(full_o), 32'h0);
      if (i == 7) chk("c0_full7", 32'(full_o), 32'h1);
    end
    push_i = '0;
    chk("c0_full8", 32'(full_o), 32'h1);
    chk("c0_req",   32'(req_o), 32'h1);
    for (int k = 0; k < 7; k++) begin
      gnt_i = 4'b0001;
      tick();
      gnt_i = '0;
      chk("c0_drain_valid", 32'(xfer_valid_o), 32'h1);
      tick();
      chk("c0_drain_done", 32'(done_o), 32'h1);
      tick();
      if (k == 0) chk("c0_full_after1", 32'(full_o), 32'h0);
    end
    chk("c0_empty_req", 32'(req_o), 32'h0);

    // Client 1 at max, push coinciding with its done
    push_i = 4'b0010;
    for (int i = 0; i < 7; i++) tick();
    push_i = '0;
    chk("c1_full", 32'(full_o), 32'h2);
    gnt_i = 4'b0010;
    tick();
    gnt_i = '0;
    chk("c1_valid", 32'(xfer_valid_o), 32'h1);
    tick();
    chk("c1_done", 32'(done_o), 32'h2);
    push_i = 4'b0010;
    tick();
    push_i = '0;
    chk("c1_full_hold", 32'(full_o), 32'h2);
    chk("c1_req",       32'(req_o), 32'h2);
    for (int k = 0; k < 7; k++) begin
      gnt_i = 4'b0010;
      tick();
      gnt_i = '0;
      chk("c1_drain_valid", 32'(xfer_valid_o), 32'h1);
      tick();
      chk("c1_drain_done", 32'(done_o), 32'h2);
      tick();
      if (k == 0) chk("c1_full_after1", 32'(full_o), 32'h0);
    end
    chk("c1_empty_req", 32'(req_o), 32'h0);

    // Multi-hot grant: lowest index wins; checker flags it
    push_i = 4'b0011;
    tick();
    push_i = '0;
    chk("mh_req", 32'(req_o), 32'h3);
    gnt_i = 4'b0011;
    tick();
    gnt_i = '0;
    chk("mh_id",    32'(xfer_id_o), 32'h0);
    chk("mh_valid", 32'(xfer_valid_o), 32'h1);
    chk("mh_err",   32'(err_o), 32'(EXP_ERR));
    tick();
    chk("mh_done", 32'(done_o), 32'h1);
    tick();
    chk("mh_req_left", 32'(req_o), 32'h2);
    chk("mh_err_sticky", 32'(err_o), 32'(EXP_ERR));

    // Reset asserted mid-transfer aborts everything
    gnt_i = 4'b0010;
    tick();
    gnt_i = '0;
    chk("ab_valid", 32'(xfer_valid_o), 32'h1);
    chk("ab_id",    32'(xfer_id_o), 32'h1);
    reset = 1'b0;
    #1;
    chk("ab_rst_valid", 32'(xfer_valid_o), 32'h0);
    chk("ab_rst_done",  32'(done_o), 32'h0);
    chk("ab_rst_req",   32'(req_o), 32'h0);
    chk("ab_rst_id",    32'(xfer_id_o), 32'h0);
    chk("ab_rst_err",   32'(err_o), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("ab_post_done",  32'(done_o), 32'h0);
    chk("ab_post_req",   32'(req_o), 32'h0);
    chk("ab_post_valid", 32'(xfer_valid_o), 32'h0);

    // Grant without request is ignored
    gnt_i = 4'b0100;
    tick();
    gnt_i = '0;
    chk("ng_valid", 32'(xfer_valid_o), 32'h0);
    chk("ng_req",   32'(req_o), 32'h0);
    chk("ng_err",   32'(err_o), 32'(EXP_ERR));

    // Grant held into XFER: ignored functionally, flagged by checker
    reset = 1'b0;
    #1;
    chk("gx_rst_err", 32'(err_o), 32'h0);
    reset = 1'b1;
    push_i = 4'b0001;
    tick();
    push_i = '0;
    gnt_i = 4'b0001;
    tick();
    chk("gx_valid",   32'(xfer_valid_o), 32'h1);
    chk("gx_err_ok",  32'(err_o), 32'h0);
    tick();
    gnt_i = '0;
    chk("gx_done", 32'(done_o), 32'h1);
    chk("gx_err",  32'(err_o), 32'(EXP_ERR));
    tick();
    chk("gx_idle", 32'(xfer_valid_o), 32'h0);
    chk("gx_req",  32'(req_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
